// File: rtl/multiexp_pnt_scl_feeder_if.sv
// Streaming handshake bundle (val/rdy/dat + sop/eop/err/mod/ctl).
// Ports: source drives payload and val, sink drives rdy.
interface if_axi_stream #(
  parameter int DAT_BITS = 8,
  parameter int CTL_BITS = 8,
  parameter int MOD_BITS = 8
);
  logic                val;
  logic                rdy;
  logic [DAT_BITS-1:0] dat;
  logic                sop;
  logic                eop;
  logic                err;
  logic [MOD_BITS-1:0] mod;
  logic [CTL_BITS-1:0] ctl;

  modport source (
    output val, dat, sop, eop, err, mod, ctl,
    input  rdy
  );
  modport sink (
    input  val, dat, sop, eop, err, mod, ctl,
    output rdy
  );
endinterface

// File: rtl/multiexp_pnt_scl_feeder.sv
// Joins point/scalar streams, passes pass 0 through while buffering it,
// then replays the buffer KEY_BITS-1 more times.
// Ports: i_clk, i_rst (sync, high), i_num_in/i_start job control,
// i_pnt_if/i_scl_if sinks, o_pnt_scl_if source {pnt,scl}, o_busy, o_err.
module multiexp_pnt_scl_feeder #(
  parameter int P_BITS     = 768,
  parameter int S_BITS     = 256,
  parameter int KEY_BITS   = 256,
  parameter int MAX_NUM_IN = 1024,
  parameter int CTL_BITS   = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [63:0]  i_num_in,
  input  logic         i_start,
  if_axi_stream.sink   i_pnt_if,
  if_axi_stream.sink   i_scl_if,
  if_axi_stream.source o_pnt_scl_if,
  output logic         o_busy,
  output logic         o_err
);
  localparam int D  = P_BITS + S_BITS;
  localparam int IW = MAX_NUM_IN > 1 ? $clog2(MAX_NUM_IN) : 1;
  localparam int PW = KEY_BITS > 1 ? $clog2(KEY_BITS) : 1;
  localparam int NW = $clog2(MAX_NUM_IN + 1);

  typedef enum logic [1:0] {IDLE, LOAD, REPLAY} state_t;

  state_t state, state_nxt;

  logic [IW-1:0] idx;
  logic [PW-1:0] pass;
  logic [NW-1:0] num;
  logic          done;

  logic [D-1:0] mem [MAX_NUM_IN];
  logic         rd_vld;
  logic         rd_eop;
  logic [D-1:0] rd_dat;

  logic [1:0]   cnt;
  logic [D-1:0] q0_dat, q1_dat;
  logic         q0_sop, q0_eop;
  logic         q1_sop, q1_eop;

  logic         start_ok;
  logic         pop;
  logic         free;
  logic         loading;
  logic         join_ok;
  logic         issue;
  logic         idx_last;
  logic         pass_last;
  logic         push;
  logic         push_sop;
  logic         push_eop;
  logic [D-1:0] push_dat;

  assign start_ok  = (i_num_in != 64'd0) &&
                     (i_num_in <= 64'(MAX_NUM_IN));
  assign pop       = (cnt != 2'd0) && o_pnt_scl_if.rdy;
  assign free      = (cnt != 2'd2) || pop;
  assign loading   = (state == LOAD) && !done && free;
  assign join_ok   = loading && i_pnt_if.val && i_scl_if.val;
  assign idx_last  = (NW'(idx) + NW'(1)) == num;
  assign pass_last = pass == PW'(KEY_BITS - 1);

  // A read issued now lands in the skid next cycle, so the skid
  // occupancy after this cycle's pop plus the in-flight read must
  // leave room for it.
  assign issue = (state == REPLAY) && !done &&
                 ({1'b0, cnt} + {2'b0, rd_vld} <= {2'b0, pop} + 3'd1);

  assign i_pnt_if.rdy = loading && i_scl_if.val;
  assign i_scl_if.rdy = loading && i_pnt_if.val;

  assign push     = join_ok || rd_vld;
  assign push_dat = rd_vld ? rd_dat : {i_pnt_if.dat, i_scl_if.dat};
  assign push_sop = !rd_vld && (idx == '0) && (pass == '0);
  assign push_eop = rd_vld ? rd_eop : (idx_last && pass_last);

  assign o_pnt_scl_if.val = cnt != 2'd0;
  assign o_pnt_scl_if.dat = q0_dat;
  assign o_pnt_scl_if.sop = q0_sop;
  assign o_pnt_scl_if.eop = q0_eop;
  assign o_pnt_scl_if.err = 1'b0;
  assign o_pnt_scl_if.mod = '0;
  assign o_pnt_scl_if.ctl = '0;

  assign o_busy = state != IDLE;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      state == IDLE:
        if (i_start && start_ok) state_nxt = LOAD;
      state == LOAD:
        if (join_ok && idx_last && !pass_last) state_nxt = REPLAY;
      default: ;
    endcase
    if (pop && q0_eop) state_nxt = IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx  <= '0;
      pass <= '0;
      num  <= '0;
      done <= 1'b0;
    end else if (state == IDLE) begin
      if (i_start && start_ok) begin
        num  <= NW'(i_num_in);
        idx  <= '0;
        pass <= '0;
        done <= 1'b0;
      end
    end else if (join_ok || issue) begin
      if (idx_last) begin
        idx  <= '0;
        pass <= pass + PW'(1);
        if (pass_last) done <= 1'b1;
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_vld <= 1'b0;
      rd_eop <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      rd_vld <= issue;
      rd_eop <= idx_last && pass_last;
      o_err  <= (state == IDLE) && i_start && !start_ok;
    end
  end

  always_ff @(posedge i_clk) begin
    if (join_ok) mem[idx] <= push_dat;
    if (issue)   rd_dat   <= mem[idx];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt    <= 2'd0;
      q0_dat <= '0;
      q0_sop <= 1'b0;
      q0_eop <= 1'b0;
      q1_dat <= '0;
      q1_sop <= 1'b0;
      q1_eop <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            q0_dat <= push_dat;
            q0_sop <= push_sop;
            q0_eop <= push_eop;
          end else begin
            q1_dat <= push_dat;
            q1_sop <= push_sop;
            q1_eop <= push_eop;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          q0_dat <= q1_dat;
          q0_sop <= q1_sop;
          q0_eop <= q1_eop;
          cnt    <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            q0_dat <= push_dat;
            q0_sop <= push_sop;
            q0_eop <= push_eop;
          end else begin
            q0_dat <= q1_dat;
            q0_sop <= q1_sop;
            q0_eop <= q1_eop;
            q1_dat <= push_dat;
            q1_sop <= push_sop;
            q1_eop <= push_eop;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multiexp_pnt_scl_feeder.sv
// Bench for multiexp_pnt_scl_feeder: table of jobs plus a reset-in-replay
// sequence, checked against a queue of expected beats.
module tb_multiexp_pnt_scl_feeder;
  localparam int P = 16;
  localparam int S = 16;
  localparam int K = 4;
  localparam int M = 8;
  localparam int D = P + S;

  typedef struct {
    logic [D-1:0] dat;
    bit           sop;
    bit           eop;
  } beat_t;

  typedef struct {
    logic [63:0] num;
    bit          rnd;
    int          dly;
    bit          mid;
    bit          fixed;
    bit          exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] num_in = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        err;

  if_axi_stream #(.DAT_BITS(P), .CTL_BITS(8)) p_if ();
  if_axi_stream #(.DAT_BITS(S), .CTL_BITS(8)) s_if ();
  if_axi_stream #(.DAT_BITS(D), .CTL_BITS(8)) o_if ();

  multiexp_pnt_scl_feeder #(
    .P_BITS(P), .S_BITS(S), .KEY_BITS(K),
    .MAX_NUM_IN(M), .CTL_BITS(8)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_num_in(num_in), .i_start(start),
    .i_pnt_if(p_if), .i_scl_if(s_if), .o_pnt_scl_if(o_if),
    .o_busy(busy), .o_err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rx_cnt = 0;
  int p_used = 0;
  int s_used = 0;
  int beat_cyc [64];

  logic [P-1:0] pq [$];
  logic [S-1:0] sq [$];
  beat_t        expq [$];

  bit p_en = 1'b0;
  bit s_en = 1'b0;
  bit rnd = 1'b0;
  bit pf, sf, of;
  bit hold_v = 1'b0;
  logic [D-1:0] hold_d;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    p_if.sop = 0; p_if.eop = 0; p_if.err = 0; p_if.mod = '0; p_if.ctl = '0;
    s_if.sop = 0; s_if.eop = 0; s_if.err = 0; s_if.mod = '0; s_if.ctl = '0;
    p_if.val = 0; p_if.dat = '0;
    s_if.val = 0; s_if.dat = '0;
    o_if.rdy = 1'b1;
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (pf && pq.size() > 0) begin void'(pq.pop_front()); p_used++; end
    if (sf && sq.size() > 0) begin void'(sq.pop_front()); s_used++; end
    p_if.val = p_en && (pq.size() > 0);
    p_if.dat = (pq.size() > 0) ? pq[0] : '0;
    s_if.val = s_en && (sq.size() > 0);
    s_if.dat = (sq.size() > 0) ? sq[0] : '0;
    o_if.rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    beat_t e;
    pf = p_if.val && p_if.rdy;
    sf = s_if.val && s_if.rdy;
    of = o_if.val && o_if.rdy;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (pf || sf) chk("join_pair", 64'(pf), 64'(sf));
      if (hold_v) begin
        chk("val_hold", 64'(o_if.val), 64'd1);
        chk("dat_hold", 64'(o_if.dat), 64'(hold_d));
      end
      if (of) begin
        if (expq.size() == 0) begin
          chk("extra_beat", 64'(rx_cnt), 64'(-1));
        end else begin
          e = expq.pop_front();
          chk("beat_dat", 64'(o_if.dat), 64'(e.dat));
          chk("beat_sop", 64'(o_if.sop), 64'(e.sop));
          chk("beat_eop", 64'(o_if.eop), 64'(e.eop));
          chk("beat_side", 64'({o_if.ctl, o_if.err, o_if.mod}), 64'd0);
        end
        if (rx_cnt < 64) beat_cyc[rx_cnt] = cyc;
        rx_cnt++;
      end
      hold_v = o_if.val && !o_if.rdy;
      hold_d = o_if.dat;
    end
  end

  task automatic run_job(vec_t v);
    logic [P-1:0] pts [M];
    logic [S-1:0] scs [M];
    int n, total, used0;
    bit got;
    @(negedge clk);
    pq.delete(); sq.delete(); expq.delete();
    rx_cnt = 0;
    rnd = v.rnd;
    if (v.exp_err) begin
      pq.push_back(P'(16'h5555));
      sq.push_back(S'(16'h6666));
      p_en = 1'b1; s_en = 1'b1;
      @(negedge clk);
      used0 = p_used + s_used;
      num_in = v.num; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("err_pulse", 64'(err), 64'd1);
      chk("err_busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("err_len", 64'(err), 64'd0);
      chk("err_busy2", 64'(busy), 64'd0);
      chk("err_noconsume", 64'(p_used + s_used), 64'(used0));
      p_en = 1'b0; s_en = 1'b0;
      pq.delete(); sq.delete();
      return;
    end
    n = int'(v.num);
    total = n * K;
    for (int i = 0; i < n; i++) begin
      pts[i] = v.fixed ? P'(8'hA1 + i) : P'($urandom);
      scs[i] = v.fixed ? S'(8'h11 + i) : S'($urandom);
      pq.push_back(pts[i]);
      sq.push_back(scs[i]);
    end
    for (int p = 0; p < K; p++)
      for (int i = 0; i < n; i++)
        expq.push_back('{dat: {pts[i], scs[i]},
                         sop: (p == 0 && i == 0),
                         eop: (p == K - 1 && i == n - 1)});
    p_en = 1'b1;
    s_en = (v.dly == 0);
    num_in = v.num; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_err", 64'(err), 64'd0);
    chk("start_busy", 64'(busy), 64'd1);
    if (v.mid) begin
      num_in = 64'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("mid_start_err", 64'(err), 64'd0);
      chk("mid_start_busy", 64'(busy), 64'd1);
    end
    repeat (v.dly) @(negedge clk);
    s_en = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 200 + total * 8; c++) begin
      @(posedge clk);
      if (rx_cnt >= total) begin got = 1'b1; break; end
    end
    if (!got) chk("timeout", 64'(rx_cnt), 64'(total));
    @(negedge clk);
    chk("busy_fall", 64'(busy), 64'd0);
    if (!v.rnd && got)
      chk("no_bubble", 64'(beat_cyc[total-1] - beat_cyc[n]),
          64'(total - 1 - n));
    repeat (10) @(negedge clk);
    chk("beat_total", 64'(rx_cnt), 64'(total));
    p_en = 1'b0; s_en = 1'b0;
  endtask

  initial begin
    vec_t tbl [9];
    vec_t rv;
    bit got;
    tbl[0] = '{num: 3, rnd: 0, dly: 0, mid: 0, fixed: 1, exp_err: 0};
    tbl[1] = '{num: 3, rnd: 1, dly: 5, mid: 0, fixed: 1, exp_err: 0};
    tbl[2] = '{num: 1, rnd: 0, dly: 0, mid: 0, fixed: 0, exp_err: 0};
    tbl[3] = '{num: 0, rnd: 0, dly: 0, mid: 0, fixed: 0, exp_err: 1};
    tbl[4] = '{num: M + 1, rnd: 0, dly: 0, mid: 0, fixed: 0, exp_err: 1};
    tbl[5] = '{num: 64'h1_0000_0003, rnd: 0, dly: 0, mid: 0, fixed: 0,
               exp_err: 1};
    tbl[6] = '{num: M, rnd: 0, dly: 0, mid: 0, fixed: 0, exp_err: 0};
    tbl[7] = '{num: M, rnd: 1, dly: 2, mid: 0, fixed: 0, exp_err: 0};
    tbl[8] = '{num: 3, rnd: 0, dly: 5, mid: 1, fixed: 0, exp_err: 0};

    repeat (3) @(negedge clk);
    chk("rst_val", 64'(o_if.val), 64'd0);
    chk("rst_sop_eop", 64'({o_if.sop, o_if.eop}), 64'd0);
    chk("rst_rdy", 64'({p_if.rdy, s_if.rdy}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;

    foreach (tbl[t]) run_job(tbl[t]);

    @(negedge clk);
    pq.delete(); sq.delete(); expq.delete();
    rx_cnt = 0; rnd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pq.push_back(P'($urandom));
      sq.push_back(S'($urandom));
    end
    for (int p = 0; p < K; p++)
      for (int i = 0; i < 3; i++)
        expq.push_back('{dat: {pq[i], sq[i]},
                         sop: (p == 0 && i == 0),
                         eop: (p == K - 1 && i == 2)});
    p_en = 1'b1; s_en = 1'b1;
    num_in = 64'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      if (rx_cnt >= 7) begin got = 1'b1; break; end
    end
    if (!got) chk("rst_wait_timeout", 64'(rx_cnt), 64'd7);
    @(negedge clk);
    rst = 1'b1;
    expq.delete();
    p_en = 1'b0; s_en = 1'b0;
    @(negedge clk);
    chk("midrst_val", 64'(o_if.val), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    rv = '{num: 2, rnd: 0, dly: 0, mid: 0, fixed: 0, exp_err: 0};
    run_job(rv);
    rv = '{num: 2, rnd: 1, dly: 0, mid: 0, fixed: 0, exp_err: 0};
    run_job(rv);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
